sum_serial_nb: RTL and testbench
================================

// Module: sum_serial_nb
// PURPOSE
//  - Bit-serial N-bit adder: one full-adder slice plus a carry flip-flop, processing LSB first over WIDTH cycles.
//  - Successor to the combinational 1-bit full-adder lab stage; adds a start/busy/done handshake and operand width WIDTH.
//  - Sits between operand registers (switches/regs) and a result display/register stage.
// PARAMETERS
//  - WIDTH   4   operand and result width in bits (>=2)
//  - CNT_W   $clog2(WIDTH+1)   bit-counter width (localparam, not overridable)
// PORTS
//  - clk    in   1      system clock, rising edge
//  - rst    in   1      synchronous, active-high reset
//  - start  in   1      request: capture A, B, Ci and begin an operation
//  - A      in   WIDTH  operand A, sampled only on accepted start
//  - B      in   WIDTH  operand B, sampled only on accepted start
//  - Ci     in   1      carry-in, sampled only on accepted start
//  - busy   out  1      high while an operation is in progress
//  - done   out  1      one-cycle pulse: S/Cout valid
//  - S      out  WIDTH  sum, held until the next accepted start completes
//  - Cout   out  1      carry out of bit WIDTH-1, held with S
//  - op_sub in   1      SUM_SERIAL_SUB_EN only: 1 = A-B, sampled on accepted start
// BEHAVIOUR
//  - One clock (clk); reset is synchronous and active-high (rst).
//  - Reset: state=IDLE; busy=0, done=0, S=0, Cout=0; internal shift regs, carry FF, counter=0.
//  - FSM states: IDLE, RUN, DONE.
//    - IDLE: if start, load opA<=A, opB<=B, carry<=Ci, cnt<=0; go to RUN.
//    - RUN: each cycle, s_i=opA[0]^opB[0]^carry; carry<=maj(opA[0],opB[0],carry).
//      Shift opA/opB right; shift s_i into result MSB (result shifts right); cnt<=cnt+1.
//      When cnt==WIDTH-1, go to DONE.
//    - DONE: done=1 for exactly this cycle; S<=result, Cout<=carry already registered on the entry edge.
//      If start is high in DONE, accept it (go to RUN, same load as IDLE); else go to IDLE.
//  - Latency: start sampled at edge k -> busy high after edges k+1..k+WIDTH.
//    done high for one cycle after edge k+WIDTH+1; back-to-back throughput is one op per WIDTH+1 cycles.
//  - busy = (state==RUN); done = (state==DONE); both registered.
//  - start while busy: ignored, with no effect on operands or progress.
//  - Arithmetic: unsigned, modulo 2^WIDTH; Cout is the true carry out; {Cout,S} = A+B+Ci.
//  - S/Cout update only on entry to DONE; they never show partial results.
//  - rst mid-RUN: operation aborted; all outputs cleared on the next edge; no done pulse.
//  - Inputs A/B/Ci may change freely during RUN without effect.
// CONFIGURATION
//  - Macro SUM_SERIAL_SUB_EN:
//    - Defined: port op_sub exists. On accepted start with op_sub=1, load opB<=~B and carry<=1 (Ci ignored).
//      This gives S=A-B mod 2^WIDTH; Cout=1 means no borrow (A>=B). With op_sub=0, behaviour is identical to undefined.
//    - Undefined: no op_sub port; add only.
// TESTING (WIDTH=4)
//  - T1: rst 2 cycles, start A=5 B=3 Ci=0 -> busy 4 cycles, done pulse 1 cycle, S=8 Cout=0, held after.
//  - T2: A=15 B=1 Ci=0 -> S=0 Cout=1; then A=15 B=15 Ci=1 -> S=15 Cout=1.
//  - T3: exhaustive sweep of all 512 A/B/Ci combos, back-to-back with start held in DONE -> {Cout,S}==A+B+Ci each done; period 5 cycles.
//  - T4: start A=1 B=2, pulse start with A=7 B=7 during RUN -> result S=3 Cout=0, second request dropped.
//  - T5: start A=9 B=9, assert rst at the 2nd RUN cycle -> next edge busy=0, done=0, S=0, Cout=0; no done pulse.
//  - T6 (SUM_SERIAL_SUB_EN): op_sub=1, A=3 B=5 -> S=14 Cout=0; A=5 B=3 -> S=2 Cout=1; op_sub=0 repeats T1.

Source files
------------

// File: rtl/sum_serial_nb.sv
// sum_serial_nb: bit-serial WIDTH-bit adder (one full-adder slice plus a carry
// flip-flop), processing the operands LSB first over WIDTH cycles.
//
// Ports:
//   clk    - system clock, rising edge
//   rst    - synchronous, active-high reset
//   start  - capture A, B, Ci and begin an operation (accepted in IDLE/DONE)
//   A, B   - WIDTH-bit operands, sampled only on an accepted start
//   Ci     - carry-in, sampled only on an accepted start
//   op_sub - (SUM_SERIAL_SUB_EN only) 1 = compute A-B, sampled on accepted start
//   busy   - high while an operation is in progress
//   done   - one-cycle pulse, S/Cout hold the new result
//   S      - sum, held until the next accepted start completes
//   Cout   - carry out of bit WIDTH-1, held with S
//
// Optional feature: define SUM_SERIAL_SUB_EN to add op_sub and subtraction.
module sum_serial_nb #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Ci,
`ifdef SUM_SERIAL_SUB_EN
  input  logic             op_sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] S,
  output logic             Cout
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state_q;
  logic [WIDTH-1:0]   opa_q;
  logic [WIDTH-1:0]   opb_q;
  logic               carry_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [WIDTH-1:0]   s_q;
  logic               cout_q;

  // Values loaded on an accepted start.
  logic [WIDTH-1:0]   ld_b;
  logic               ld_c;

`ifdef SUM_SERIAL_SUB_EN
  // Two's-complement subtraction: A + ~B + 1; Ci is ignored.
  assign ld_b = op_sub ? ~B : B;
  assign ld_c = op_sub | Ci;
`else
  assign ld_b = B;
  assign ld_c = Ci;
`endif

  // Full-adder slice on the current LSBs.
  logic             s_bit;
  logic             c_next;
  logic [WIDTH-1:0] opa_d;

  assign s_bit  = opa_q[0] ^ opb_q[0] ^ carry_q;
  assign c_next = (opa_q[0] & opb_q[0]) | (opa_q[0] & carry_q) | (opb_q[0] & carry_q);
  // opA doubles as the result shift register: each consumed LSB frees the
  // MSB, which takes the new sum bit, so after WIDTH shifts it holds the sum.
  assign opa_d  = {s_bit, opa_q[WIDTH-1:1]};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      opa_q   <= '0;
      opb_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      s_q     <= '0;
      cout_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (start) begin
            opa_q   <= A;
            opb_q   <= ld_b;
            carry_q <= ld_c;
            cnt_q   <= '0;
            state_q <= RUN;
          end else begin
            state_q <= IDLE;
          end
        end
        RUN: begin
          opa_q   <= opa_d;
          opb_q   <= opb_q >> 1;
          carry_q <= c_next;
          cnt_q   <= cnt_q + 1'b1;
          if (cnt_q == CNT_W'(WIDTH - 1)) begin
            s_q     <= opa_d;
            cout_q  <= c_next;
            state_q <= DONE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy = (state_q == RUN);
  assign done = (state_q == DONE);
  assign S    = s_q;
  assign Cout = cout_q;

endmodule

// File: tb/tb_sum_serial_nb.sv
// Testbench for sum_serial_nb (WIDTH=4): vector table, random ops against a
// plain-arithmetic model, exhaustive back-to-back sweep, and hand-written
// corner sequences (start during RUN, reset mid-RUN).
module tb_sum_serial_nb;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic         Ci;
  logic         op_sub;
  logic         busy;
  logic         done;
  logic [W-1:0] S;
  logic         Cout;

  int checks = 0;
  int errors = 0;
  logic [W-1:0] last_s;
  logic         last_c;

  always #5 clk = ~clk;

  sum_serial_nb #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .A     (A),
    .B     (B),
    .Ci    (Ci),
`ifdef SUM_SERIAL_SUB_EN
    .op_sub(op_sub),
`endif
    .busy  (busy),
    .done  (done),
    .S     (S),
    .Cout  (Cout)
  );

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         ci;
    logic         sub;
    logic [W-1:0] s;
    logic         c;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d want %0d", nm, got, exp);
    end
  endtask

  // Reference model straight from the arithmetic definition.
  task automatic model(input int a, input int b, input int ci, input int sub,
                       output logic [W-1:0] s, output logic c);
    int r;
    if (sub != 0) begin
      r = (a - b) & ((1 << W) - 1);
      s = r[W-1:0];
      c = (a >= b);
    end else begin
      r = a + b + ci;
      s = r[W-1:0];
      c = r[W];
    end
  endtask

  // One isolated operation with full handshake and hold checks. Inputs are
  // scrambled while busy to show they are ignored.
  task automatic do_op(input string nm, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic ci, input logic sub,
                       input logic [W-1:0] es, input logic ec);
    int n;
    @(negedge clk);
    A = a; B = b; Ci = ci; op_sub = sub; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (busy === 1'b1 && n < 20) begin
      chk({nm, " S_hold_run"}, {Cout, S}, {last_c, last_s});
      A = W'($urandom); B = W'($urandom); Ci = 1'($urandom); op_sub = 1'($urandom);
      n++;
      @(negedge clk);
    end
    chk({nm, " busy_cycles"}, n, W);
    chk({nm, " done"}, done, 1);
    chk({nm, " S"}, S, es);
    chk({nm, " Cout"}, Cout, ec);
    @(negedge clk);
    chk({nm, " done_pulse"}, done, 0);
    chk({nm, " idle"}, busy, 0);
    chk({nm, " S_hold"}, {Cout, S}, {ec, es});
    last_s = es;
    last_c = ec;
  endtask

  initial begin
    logic [W-1:0] es;
    logic         ec;
    int           n;
    int           a, b, c, sub;

    rst = 1'b1; start = 1'b0; A = '0; B = '0; Ci = 1'b0; op_sub = 1'b0;
    last_s = '0; last_c = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset busy", busy, 0);
    chk("reset done", done, 0);
    chk("reset S", S, 0);
    chk("reset Cout", Cout, 0);
    rst = 1'b0;

    // Directed vectors: {a, b, ci, sub, s, cout}
    vecs.push_back('{4'd5,  4'd3,  1'b0, 1'b0, 4'd8,  1'b0});
    vecs.push_back('{4'd15, 4'd1,  1'b0, 1'b0, 4'd0,  1'b1});
    vecs.push_back('{4'd15, 4'd15, 1'b1, 1'b0, 4'd15, 1'b1});
    vecs.push_back('{4'd0,  4'd0,  1'b0, 1'b0, 4'd0,  1'b0});
    vecs.push_back('{4'd0,  4'd0,  1'b1, 1'b0, 4'd1,  1'b0});
    vecs.push_back('{4'd10, 4'd5,  1'b1, 1'b0, 4'd0,  1'b1});
    vecs.push_back('{4'd8,  4'd8,  1'b0, 1'b0, 4'd0,  1'b1});
    vecs.push_back('{4'd7,  4'd8,  1'b0, 1'b0, 4'd15, 1'b0});
`ifdef SUM_SERIAL_SUB_EN
    vecs.push_back('{4'd3,  4'd5,  1'b0, 1'b1, 4'd14, 1'b0});
    vecs.push_back('{4'd5,  4'd3,  1'b0, 1'b1, 4'd2,  1'b1});
    vecs.push_back('{4'd5,  4'd3,  1'b1, 1'b1, 4'd2,  1'b1});
    vecs.push_back('{4'd9,  4'd9,  1'b0, 1'b1, 4'd0,  1'b1});
    vecs.push_back('{4'd5,  4'd3,  1'b0, 1'b0, 4'd8,  1'b0});
`endif
    foreach (vecs[i])
      do_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].ci, vecs[i].sub,
            vecs[i].s, vecs[i].c);

    // Random operations against the model.
    for (int i = 0; i < 100; i++) begin
      a = int'($urandom_range(0, 15));
      b = int'($urandom_range(0, 15));
      c = int'($urandom_range(0, 1));
`ifdef SUM_SERIAL_SUB_EN
      sub = int'($urandom_range(0, 1));
`else
      sub = 0;
`endif
      model(a, b, c, sub, es, ec);
      do_op($sformatf("rand%0d", i), W'(a), W'(b), 1'(c), 1'(sub), es, ec);
    end

    // Exhaustive back-to-back sweep with start held high; one result per
    // W+1 cycles, next operands presented while the current one runs.
    @(negedge clk);
    A = '0; B = '0; Ci = 1'b0; op_sub = 1'b0; start = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 512; i++) begin
      n = 0;
      while (done !== 1'b1 && n < 20) begin
        n++;
        @(negedge clk);
      end
      model(i & 15, (i >> 4) & 15, (i >> 8) & 1, 0, es, ec);
      chk($sformatf("sweep%0d period", i), n, W);
      chk($sformatf("sweep%0d sum", i), {Cout, S}, {ec, es});
      last_s = es; last_c = ec;
      if (i < 511) begin
        A = W'((i + 1) & 15); B = W'(((i + 1) >> 4) & 15); Ci = 1'(((i + 1) >> 8) & 1);
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
    end
    chk("sweep end idle", {busy, done}, 0);

    // Start pulsed during RUN is dropped.
    @(negedge clk);
    A = 4'd1; B = 4'd2; Ci = 1'b0; op_sub = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    A = 4'd7; B = 4'd7; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (done !== 1'b1 && n < 20) begin
      n++;
      @(negedge clk);
    end
    chk("drop latency", n, 2);
    chk("drop result", {Cout, S}, {1'b0, 4'd3});
    @(negedge clk);
    chk("drop no rerun", {busy, done}, 0);
    repeat (6) @(negedge clk);
    chk("drop still idle", {busy, done, S}, {2'b00, 4'd3});
    last_s = 4'd3; last_c = 1'b0;

    // Reset during the second RUN cycle aborts the operation.
    A = 4'd9; B = 4'd9; Ci = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("abort busy1", busy, 1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("abort busy", busy, 0);
    chk("abort done", done, 0);
    chk("abort S", S, 0);
    chk("abort Cout", Cout, 0);
    rst = 1'b0;
    n = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (done === 1'b1 || busy === 1'b1) n++;
    end
    chk("abort no done", n, 0);
    last_s = '0; last_c = 1'b0;

    do_op("after abort", 4'd5, 4'd3, 1'b0, 1'b0, 4'd8, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
